// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture block.
package la_pkg;

    localparam int LA_WIDTH = 15;
    localparam int LA_DEPTH = 64;
    localparam int LA_AW    = 6;

    // Capture FSM states; also the encoding seen on the debug state output.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4,
        ST_READ      = 3'd5
    } la_state_e;

endpackage

// File: rtl/la_capture_if.sv
// Trace readout stream between the capture block and the host-interface logic.
//
// Handshake: a beat transfers on a rising clk edge where rd_valid && rd_ready.
// While rd_valid is high and rd_ready is low, rd_data and rd_last hold stable
// and rd_valid stays high. rd_ready may change freely and has no effect while
// rd_valid is low.
interface la_capture_if #(parameter int WIDTH = 15);

    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);

endinterface

// File: rtl/la_trace_ram.sv
// Trace buffer: simple dual-port RAM, one write port and one registered read port.
module la_trace_ram #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port and registered read; the read register holds when i_re is low.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/la_capture.sv
// Logic-analyser capture: probe synchronizer, mask/value trigger, circular
// trace buffer with programmable pretrigger, and oldest-first stream readout.
module la_capture
    import la_pkg::*;
#(
    parameter int WIDTH = LA_WIDTH,
    parameter int DEPTH = LA_DEPTH,
    parameter int AW    = LA_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] probe,
    input  logic             arm,
    input  logic             abort,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic [AW:0]      post_count,
    la_capture_if.master     rd,
    output logic             armed,
    output logic             triggered,
    output logic             done,
    output la_state_e        o_dbg_state
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_FILL = ST_FILL;
    localparam logic [2:0] S_WAIT = ST_WAIT_TRIG;
    localparam logic [2:0] S_POST = ST_POST;
    localparam logic [2:0] S_DONE = ST_DONE;
    localparam logic [2:0] S_READ = ST_READ;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    // Synchronizer and sample register
    logic [WIDTH-1:0] r_sync1, r_sync2, r_s;

    // FSM, pointers, counters
    logic [2:0]    r_state;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_pc, r_pre, r_remain;
    logic          r_triggered;

    // Readout stage: RAM output register (stage 1) feeding the output register
    logic             r_s1_valid;
    logic [AW:0]      r_issue_cnt, r_load_cnt;
    logic             r_rd_valid, r_rd_last;
    logic [WIDTH-1:0] r_rd_data;

    logic [AW:0]      w_pc_clamped;
    logic             w_match, w_we, w_re;
    logic             w_out_take, w_s1_move, w_s1_free, w_rd_xfer, w_rd_flush;
    logic [WIDTH-1:0] w_ram_q;

    assign w_match    = ((r_s ^ trig_value) & trig_mask) == '0;
    assign w_we       = !abort && (r_state == S_FILL || r_state == S_WAIT || r_state == S_POST);
    assign w_rd_xfer  = r_rd_valid && rd.rd_ready;
    assign w_out_take = !r_rd_valid || rd.rd_ready;
    assign w_s1_move  = r_s1_valid && w_out_take;
    assign w_s1_free  = !r_s1_valid || w_s1_move;

    // The first read is issued in DONE so data is at the output two cycles later;
    // in READ a new read is issued whenever stage 1 is empty or draining.
    assign w_re = !abort &&
                  ((r_state == S_DONE && !arm) ||
                   (r_state == S_READ && r_issue_cnt < DEPTH_W && w_s1_free));

    // Readout state is discarded on abort, re-arm, any non-readout state,
    // and right after the final beat transfers.
    assign w_rd_flush = abort ||
                        !(r_state == S_DONE || r_state == S_READ) ||
                        (r_state == S_DONE && arm) ||
                        (w_rd_xfer && r_rd_last);

    // Clamp the requested post-trigger count into 1..DEPTH.
    always_comb begin
        w_pc_clamped = post_count;
        if (post_count == '0) begin
            w_pc_clamped = ONE_W;
        end else if (post_count > DEPTH_W) begin
            w_pc_clamped = DEPTH_W;
        end
    end

    // Two-flop synchronizer followed by the sample register s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_s     <= '0;
        end else begin
            r_sync1 <= probe;
            r_sync2 <= r_sync1;
            r_s     <= r_sync2;
        end
    end

    // Capture FSM with write pointer, pretrigger and post-trigger counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pc        <= '0;
            r_pre       <= '0;
            r_remain    <= '0;
            r_triggered <= 1'b0;
        end else if (abort) begin
            r_state     <= S_IDLE;
            r_triggered <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        r_pc        <= w_pc_clamped;
                        r_pre       <= DEPTH_W - w_pc_clamped;
                        r_wr_ptr    <= '0;
                        r_triggered <= 1'b0;
                        r_state     <= (w_pc_clamped == DEPTH_W) ? S_WAIT : S_FILL;
                    end else if (r_state == S_DONE) begin
                        r_state <= S_READ;
                        if (w_re) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_pre    <= r_pre - ONE_W;
                    if (r_pre == ONE_W) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_match) begin
                        r_triggered <= 1'b1;
                        r_remain    <= r_pc - ONE_W;
                        if (r_pc == ONE_W) begin
                            // Oldest sample sits just past the final write.
                            r_rd_ptr <= r_wr_ptr + 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_remain <= r_remain - ONE_W;
                    if (r_remain == ONE_W) begin
                        r_rd_ptr <= r_wr_ptr + 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_READ: begin
                    if (w_re) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    if (w_rd_xfer && r_rd_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Prefetching readout pipeline: stage-1 valid tracking and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_issue_cnt <= '0;
            r_load_cnt  <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
        end else if (w_rd_flush) begin
            r_s1_valid  <= 1'b0;
            r_issue_cnt <= '0;
            r_load_cnt  <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            if (w_re) begin
                r_s1_valid  <= 1'b1;
                r_issue_cnt <= r_issue_cnt + ONE_W;
            end else if (w_s1_move) begin
                r_s1_valid <= 1'b0;
            end
            if (w_out_take) begin
                r_rd_valid <= r_s1_valid;
                r_rd_data  <= w_ram_q;
                r_rd_last  <= r_s1_valid && (r_load_cnt == DEPTH_W - ONE_W);
                if (r_s1_valid) begin
                    r_load_cnt <= r_load_cnt + ONE_W;
                end
            end
        end
    end

    la_trace_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_s),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    assign armed       = (r_state == S_FILL) || (r_state == S_WAIT);
    assign done        = (r_state == S_DONE) || (r_state == S_READ);
    assign triggered   = r_triggered;
    assign rd.rd_valid = r_rd_valid;
    assign rd.rd_data  = r_rd_data;
    assign rd.rd_last  = r_rd_last;
    assign o_dbg_state = la_state_e'(r_state);

endmodule
